// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. Each stage resolves one CHUNK-bit slice of the sum.
// All stages freeze together whenever the output is held by backpressure.
module pipelined_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum,
    output logic [STAGES-1:0]     chunk_carry,
    output logic                  overflow
);
    localparam int CHUNK = DATA_WIDTH / STAGES;

    // Handshake: a beat moves on a rising edge when valid && ready. in_ready
    // drops only while a finished result waits (out_valid && !out_ready), and
    // then every stage, bubbles included, holds its contents.
    logic stall;

    logic [STAGES-1:0]     v_q, v_d;
    logic [STAGES-1:0]     c_q, c_d;
    logic [DATA_WIDTH-1:0] a_q  [STAGES];
    logic [DATA_WIDTH-1:0] a_d  [STAGES];
    logic [DATA_WIDTH-1:0] b_q  [STAGES];
    logic [DATA_WIDTH-1:0] b_d  [STAGES];
    logic [DATA_WIDTH-1:0] s_q  [STAGES];
    logic [DATA_WIDTH-1:0] s_d  [STAGES];
    logic [STAGES-1:0]     cc_q [STAGES];
    logic [STAGES-1:0]     cc_d [STAGES];
    logic                  ov_q, ov_d;

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic [DATA_WIDTH-1:0] pa  [STAGES];
    logic [DATA_WIDTH-1:0] pb  [STAGES];
    logic [DATA_WIDTH-1:0] ps  [STAGES];
    logic [STAGES-1:0]     pcc [STAGES];
    logic [STAGES-1:0]     pv, pc;
    logic [CHUNK:0]        chunk_sum [STAGES];

    assign stall    = v_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        pa        = '{default: '0};
        pb        = '{default: '0};
        ps        = '{default: '0};
        pcc       = '{default: '0};
        pv        = '0;
        pc        = '0;
        chunk_sum = '{default: '0};
        a_d       = '{default: '0};
        b_d       = '{default: '0};
        s_d       = '{default: '0};
        cc_d      = '{default: '0};
        v_d       = '0;
        c_d       = '0;

        pa[0] = a;
        pb[0] = sub ? ~b : b;
        pv[0] = in_valid;
        pc[0] = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            pa[k]  = a_q[k-1];
            pb[k]  = b_q[k-1];
            ps[k]  = s_q[k-1];
            pcc[k] = cc_q[k-1];
            pv[k]  = v_q[k-1];
            pc[k]  = c_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, pa[k][k*CHUNK +: CHUNK]}
                         + {1'b0, pb[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, pc[k]};
            a_d[k]                   = pa[k];
            b_d[k]                   = pb[k];
            s_d[k]                   = ps[k];
            s_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
            c_d[k]                   = chunk_sum[k][CHUNK];
            cc_d[k]                  = pcc[k];
            cc_d[k][k]               = chunk_sum[k][CHUNK];
            v_d[k]                   = pv[k];
        end

        // b here is already the effective (possibly inverted) operand.
        ov_d = (pa[STAGES-1][DATA_WIDTH-1] == pb[STAGES-1][DATA_WIDTH-1])
            && (s_d[STAGES-1][DATA_WIDTH-1] != pa[STAGES-1][DATA_WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q  <= '0;
            c_q  <= '0;
            ov_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                cc_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q  <= v_d;
            c_q  <= c_d;
            ov_q <= ov_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                s_q[k]  <= s_d[k];
                cc_q[k] <= cc_d[k];
            end
        end
    end

    assign out_valid   = v_q[STAGES-1];
    assign sum         = {c_q[STAGES-1], s_q[STAGES-1]};
    assign chunk_carry = cc_q[STAGES-1];
    assign overflow    = ov_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at DATA_WIDTH=8, STAGES=4: directed vector table,
// backpressure, mid-flight reset and a random stream against a reference model.
module tb_pipelined_adder;
    localparam int DW = 8;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a, b;
    logic          cin, sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   sum;
    logic [ST-1:0] chunk_carry;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [DW+1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        logic          sub;
        logic [DW:0]   sum;
        logic [ST-1:0] cc;
        logic          ov;
    } vec_t;

    vec_t vt[8];

    pipelined_adder #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .chunk_carry (chunk_carry),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, carry_out, result} from a plain full-width add.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic c, input logic s);
        logic [DW-1:0] ye;
        logic [DW:0]   r;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + {{DW{1'b0}}, (s ? 1'b1 : c)};
        return {(x[DW-1] == ye[DW-1]) && (r[DW-1] != x[DW-1]), r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Called at a negedge; drives one cycle, scores handshakes, returns at the next negedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                         input logic icin, input logic isub, input logic ordy,
                         output logic acc, output logic rdy_seen);
        logic [DW+1:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        acc      = iv && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {54'd0, overflow, sum}, 64'h3ff);
            end else begin
                e = exp_q.pop_front();
                chk("stream_result", {54'd0, overflow, sum}, {54'd0, e});
            end
        end
        if (acc) exp_q.push_back(model(ia, ib, icin, isub));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Single isolated op: checks acceptance, latency, result, then consumption.
    task automatic apply_vec(input vec_t v, input string name);
        int lat;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sub       = v.sub;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h5A;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(ST));
        chk({name, "_sum"}, {55'd0, sum}, {55'd0, v.sum});
        chk({name, "_chunk_carry"}, {60'd0, chunk_carry}, {60'd0, v.cc});
        chk({name, "_overflow"}, {63'd0, overflow}, {63'd0, v.ov});
        @(posedge clk);
        @(negedge clk);
        chk({name, "_drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic          acc, rdy;
        logic [DW-1:0] ra[6], rb[6];
        logic          rc[6], rs[6];
        logic [DW:0]   held;
        logic          seen;
        int            i, stall_left, base_out;

        vt[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 4'b1111, 1'b0};
        vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 4'b0111, 1'b1};
        vt[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 4'b1000, 1'b1};
        vt[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 9'h0FE, 4'b0000, 1'b0};
        vt[4] = '{8'h07, 8'h05, 1'b1, 1'b1, 9'h102, 4'b1111, 1'b0};
        vt[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 9'h047, 4'b0100, 1'b0};
        vt[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 4'b1000, 1'b1};
        vt[7] = '{8'h00, 8'h00, 1'b1, 1'b0, 9'h001, 4'b0000, 1'b0};

        // Clock/reset
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_sum", {55'd0, sum}, 64'd0);
        chk("reset_chunk_carry", {60'd0, chunk_carry}, 64'd0);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);

        // Directed table
        for (int k = 0; k < 8; k++) apply_vec(vt[k], $sformatf("vec%0d", k));

        // Six back-to-back ops, first result held for three cycles
        for (int k = 0; k < 6; k++) begin
            ra[k] = 8'($urandom_range(0, 255));
            rb[k] = 8'($urandom_range(0, 255));
            rc[k] = 1'($urandom_range(0, 1));
            rs[k] = 1'($urandom_range(0, 1));
        end
        i          = 0;
        stall_left = 3;
        seen       = 1'b0;
        held       = '0;
        base_out   = n_out;
        for (int cyc = 0; cyc < 40 && (i < 6 || exp_q.size() > 0); cyc++) begin
            logic ordy;
            int   j;
            if (out_valid && !seen) begin
                seen = 1'b1;
                held = sum;
            end
            ordy = !(seen && stall_left > 0);
            if (!ordy) begin
                chk("bp_held_sum", {55'd0, sum}, {55'd0, held});
                chk("bp_held_valid", {63'd0, out_valid}, 64'd1);
                stall_left--;
            end
            j = (i < 6) ? i : 5;
            cycle(i < 6, ra[j], rb[j], rc[j], rs[j], ordy, acc, rdy);
            if (!ordy) chk("bp_in_ready_low", {63'd0, rdy}, 64'd0);
            if (acc) i++;
        end
        chk("bp_all_accepted", 64'(i), 64'd6);
        chk("bp_result_count", 64'(n_out - base_out), 64'd6);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random valid/ready stream
        base_out = n_out;
        i        = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc, rdy);
            if (acc) i++;
        end
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, rdy);
        chk("rand_result_count", 64'(n_out - base_out), 64'(i));
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 8'(8'h10 + k), 8'h22, 1'b0, 1'b0, 1'b1, acc, rdy);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 8'h33;
        b        = 8'h44;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_sum", {55'd0, sum}, 64'd0);
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        base_out = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (out_valid) base_out++;
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, rdy);
        end
        chk("midreset_dropped", 64'(base_out), 64'd0);
        apply_vec(vt[4], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
